// File: rtl/tb_pkg.sv
// rtl/tb_pkg.sv - shared types for the report arbiter
package tb_pkg;

    localparam int TB_CYC_W     = 32;
    localparam int TB_ERR_W     = 16;
    localparam int TB_MSG_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } ctrl_state_t;

    // Message is stored at the widest supported width; unused upper bits stay zero.
    typedef struct packed {
        logic                    err;
        logic [TB_MSG_MAX_W-1:0] msg;
        logic [TB_CYC_W-1:0]     cycle;
    } rpt_t;

endpackage

// File: rtl/tb_rr_arb.sv
// rtl/tb_rr_arb.sv - round-robin one-hot grant starting after last_grant
module tb_rr_arb #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [N-1:0]    gnt
);

    logic [ID_W-1:0] idx;

    // Scan from the slot after the last grant, wrapping, and grant the first requester found.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(last_grant) + k) % N);
            if (req[idx] && (gnt == '0)) begin
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tb_report_arb.sv
// rtl/tb_report_arb.sv - testbench report arbiter with error limit and watchdog
module tb_report_arb
    import tb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MSG_W       = 32,
    parameter int MAX_ERRORS  = 1,
    parameter int WDOG_CYCLES = 100000,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [N_REQ-1:0]             req_vld_i,
    input  logic [N_REQ-1:0]             req_err_i,
    input  logic [N_REQ-1:0][MSG_W-1:0]  req_msg_i,
    output logic [N_REQ-1:0]             req_rdy_o,
    output logic                         rpt_vld_o,
    input  logic                         rpt_rdy_i,
    output logic [ID_W-1:0]              rpt_id_o,
    output logic                         rpt_err_o,
    output logic [MSG_W-1:0]             rpt_msg_o,
    output logic [TB_CYC_W-1:0]          rpt_cycle_o,
    input  logic                         kick_i,
    output logic [TB_ERR_W-1:0]          err_cnt_o,
    output logic                         finish_o,
    output logic                         timeout_o,
    output logic [TB_CYC_W-1:0]          tb_cycle_o
);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("tb_report_arb: N_REQ must be in 2..16");
    end
    if (MSG_W < 1 || MSG_W > TB_MSG_MAX_W) begin : g_bad_msg_w
        $error("tb_report_arb: MSG_W must be in 1..TB_MSG_MAX_W");
    end

    ctrl_state_t         state_q;
    logic                finish_q;
    logic [TB_CYC_W-1:0] tb_cycle_q;
    logic [N_REQ-1:0]    pend_q;
    rpt_t                slot_q [N_REQ];
    logic                out_vld_q;
    rpt_t                out_q;
    logic [ID_W-1:0]     out_id_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [TB_ERR_W-1:0] err_cnt_q;
    logic [TB_CYC_W-1:0] wdog_q;
    logic                timeout_q;

    logic [N_REQ-1:0]    accept;
    logic [N_REQ-1:0]    gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                handshake;
    logic                load;
    logic                err_inc;
    logic [TB_ERR_W-1:0] err_cnt_d;
    logic                wdog_clr;
    logic                timeout_set;
    logic                err_limit;
    logic                drain_empty;
    logic                enter_done;

    tb_rr_arb #(.N(N_REQ)) u_rr_arb (
        .req        (pend_q),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign req_rdy_o   = (state_q == ST_RUN) ? ~pend_q : '0;
    assign accept      = req_vld_i & req_rdy_o;
    assign handshake   = out_vld_q & rpt_rdy_i;
    assign load        = (|pend_q) & (~out_vld_q | rpt_rdy_i);
    assign err_inc     = handshake & out_q.err;
    assign err_cnt_d   = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
    assign err_limit   = (MAX_ERRORS != 0) && err_inc &&
                         ({16'd0, err_cnt_d} >= 32'(MAX_ERRORS));
    assign wdog_clr    = kick_i | handshake;
    assign timeout_set = (WDOG_CYCLES != 0) && !timeout_q && !wdog_clr &&
                         ((wdog_q + 32'd1) == 32'(WDOG_CYCLES));
    assign drain_empty = ~(|pend_q) & ~out_vld_q;
    assign enter_done  = (state_q == ST_DRAIN) && (drain_empty || timeout_set);

    // Binary index of the one-hot winner.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gnt_idx = ID_W'(i);
        end
    end

    // Free-running cycle stamp.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) tb_cycle_q <= '0;
        else         tb_cycle_q <= tb_cycle_q + 32'd1;
    end

    // Per-requester pending slots: capture on accept, release when moved to the output register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_q <= '0;
            for (int i = 0; i < N_REQ; i++) slot_q[i] <= '0;
        end else if (enter_done) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i]) begin
                    pend_q[i]       <= 1'b1;
                    slot_q[i].err   <= req_err_i[i];
                    slot_q[i].msg   <= TB_MSG_MAX_W'(req_msg_i[i]);
                    slot_q[i].cycle <= tb_cycle_q;
                end else if (load && gnt[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Output register: refill from the winner when empty or being consumed.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_vld_q    <= 1'b0;
            out_q        <= '0;
            out_id_q     <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else if (enter_done) begin
            out_vld_q <= 1'b0;
        end else if (load) begin
            out_vld_q    <= 1'b1;
            out_q        <= slot_q[gnt_idx];
            out_id_q     <= gnt_idx;
            last_grant_q <= gnt_idx;
        end else if (handshake) begin
            out_vld_q <= 1'b0;
        end
    end

    // Saturating count of delivered error reports.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) err_cnt_q <= '0;
        else         err_cnt_q <= err_cnt_d;
    end

    // Idle watchdog with sticky timeout flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q <= wdog_clr ? '0 : wdog_q + 32'd1;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    // Run control: RUN until an end condition, DRAIN until empty, DONE until reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_RUN;
            finish_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (err_limit || timeout_set) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enter_done) begin
                        state_q  <= ST_DONE;
                        finish_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rpt_vld_o   = out_vld_q;
    assign rpt_id_o    = out_id_q;
    assign rpt_err_o   = out_q.err;
    assign rpt_msg_o   = MSG_W'(out_q.msg);
    assign rpt_cycle_o = out_q.cycle;
    assign err_cnt_o   = err_cnt_q;
    assign finish_o    = finish_q;
    assign timeout_o   = timeout_q;
    assign tb_cycle_o  = tb_cycle_q;

endmodule

// File: tb/tb_tb_report_arb.sv
// tb/tb_tb_report_arb.sv - directed self-checking bench for tb_report_arb
module tb_tb_report_arb;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic [3:0]       req_vld = '0;
    logic [3:0]       req_err = '0;
    logic [3:0][31:0] req_msg = '0;
    logic             rpt_rdy = 1'b0;
    logic             kick = 1'b0;

    logic [3:0]  a_req_rdy, b_req_rdy, c_req_rdy;
    logic        a_rpt_vld, b_rpt_vld, c_rpt_vld;
    logic [1:0]  a_rpt_id, b_rpt_id, c_rpt_id;
    logic        a_rpt_err, b_rpt_err, c_rpt_err;
    logic [31:0] a_rpt_msg, b_rpt_msg, c_rpt_msg;
    logic [31:0] a_rpt_cycle, b_rpt_cycle, c_rpt_cycle;
    logic [15:0] a_err_cnt, b_err_cnt, c_err_cnt;
    logic        a_finish, b_finish, c_finish;
    logic        a_timeout, b_timeout, c_timeout;
    logic [31:0] a_tb_cycle, b_tb_cycle, c_tb_cycle;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    tb_report_arb #(.N_REQ(4), .MSG_W(32), .MAX_ERRORS(1), .WDOG_CYCLES(100000)) dut_a (
        .clk(clk), .arst_n(arst_n), .req_vld_i(req_vld), .req_err_i(req_err), .req_msg_i(req_msg),
        .req_rdy_o(a_req_rdy), .rpt_vld_o(a_rpt_vld), .rpt_rdy_i(rpt_rdy), .rpt_id_o(a_rpt_id),
        .rpt_err_o(a_rpt_err), .rpt_msg_o(a_rpt_msg), .rpt_cycle_o(a_rpt_cycle), .kick_i(kick),
        .err_cnt_o(a_err_cnt), .finish_o(a_finish), .timeout_o(a_timeout), .tb_cycle_o(a_tb_cycle)
    );

    tb_report_arb #(.N_REQ(4), .MSG_W(32), .MAX_ERRORS(2), .WDOG_CYCLES(8)) dut_b (
        .clk(clk), .arst_n(arst_n), .req_vld_i(req_vld), .req_err_i(req_err), .req_msg_i(req_msg),
        .req_rdy_o(b_req_rdy), .rpt_vld_o(b_rpt_vld), .rpt_rdy_i(rpt_rdy), .rpt_id_o(b_rpt_id),
        .rpt_err_o(b_rpt_err), .rpt_msg_o(b_rpt_msg), .rpt_cycle_o(b_rpt_cycle), .kick_i(kick),
        .err_cnt_o(b_err_cnt), .finish_o(b_finish), .timeout_o(b_timeout), .tb_cycle_o(b_tb_cycle)
    );

    tb_report_arb #(.N_REQ(4), .MSG_W(32), .MAX_ERRORS(0), .WDOG_CYCLES(0)) dut_c (
        .clk(clk), .arst_n(arst_n), .req_vld_i(req_vld), .req_err_i(req_err), .req_msg_i(req_msg),
        .req_rdy_o(c_req_rdy), .rpt_vld_o(c_rpt_vld), .rpt_rdy_i(rpt_rdy), .rpt_id_o(c_rpt_id),
        .rpt_err_o(c_rpt_err), .rpt_msg_o(c_rpt_msg), .rpt_cycle_o(c_rpt_cycle), .kick_i(kick),
        .err_cnt_o(c_err_cnt), .finish_o(c_finish), .timeout_o(c_timeout), .tb_cycle_o(c_tb_cycle)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        arst_n  = 1'b0;
        req_vld = '0;
        req_err = '0;
        rpt_rdy = 1'b0;
        kick    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        // Reset state and four simultaneous requests served in round-robin order.
        do_reset();
        check_eq("rst_vld", a_rpt_vld, 0);
        check_eq("rst_err_cnt", a_err_cnt, 0);
        check_eq("rst_finish", a_finish, 0);
        check_eq("rst_timeout", a_timeout, 0);
        check_eq("rst_tb_cycle", a_tb_cycle, 0);
        check_eq("rst_req_rdy", a_req_rdy, 4'hF);
        step_to(5);
        check_eq("cycle5_stamp", a_tb_cycle, 5);
        for (int i = 0; i < 4; i++) req_msg[i] = 32'hA000_0000 | 32'(i);
        req_vld = 4'hF;
        rpt_rdy = 1'b1;
        step();
        req_vld = '0;
        check_eq("rr_lat_cyc6", a_rpt_vld, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("rr_vld", a_rpt_vld, 1);
            check_eq("rr_id", a_rpt_id, 64'(k));
            check_eq("rr_msg", a_rpt_msg, 32'hA000_0000 | 32'(k));
            check_eq("rr_stamp", a_rpt_cycle, 5);
        end
        step();
        check_eq("rr_idle_cyc11", a_rpt_vld, 0);
        check_eq("rr_no_err", a_err_cnt, 0);

        // Backpressure: payload holds while rpt_rdy_i is low.
        do_reset();
        step_to(10);
        req_vld    = 4'b0100;
        req_msg[2] = 32'h1234_5678;
        step();
        req_vld = '0;
        check_eq("bp_vld_cyc11", a_rpt_vld, 0);
        check_eq("bp_rdy2_cyc11", a_req_rdy[2], 0);
        step();
        check_eq("bp_rdy2_cyc12", a_req_rdy[2], 1);
        for (int k = 12; k <= 15; k++) begin
            check_eq("bp_vld", a_rpt_vld, 1);
            check_eq("bp_id", a_rpt_id, 2);
            check_eq("bp_msg", a_rpt_msg, 32'h1234_5678);
            check_eq("bp_stamp", a_rpt_cycle, 10);
            if (k == 15) rpt_rdy = 1'b1;
            step();
        end
        check_eq("bp_vld_cyc16", a_rpt_vld, 0);

        // Error limit of 2: third error still drains, then DONE.
        do_reset();
        kick = 1'b1;
        step_to(5);
        req_vld = 4'b0111;
        req_err = 4'b0111;
        rpt_rdy = 1'b1;
        step();
        req_vld = '0;
        step();
        check_eq("el_id_c7", b_rpt_id, 0);
        check_eq("el_err_c7", b_rpt_err, 1);
        check_eq("el_cnt_c7", b_err_cnt, 0);
        step();
        check_eq("el_id_c8", b_rpt_id, 1);
        check_eq("el_cnt_c8", b_err_cnt, 1);
        step();
        check_eq("el_vld_c9", b_rpt_vld, 1);
        check_eq("el_id_c9", b_rpt_id, 2);
        check_eq("el_cnt_c9", b_err_cnt, 2);
        check_eq("el_rdy_drain", b_req_rdy, 0);
        check_eq("el_fin_c9", b_finish, 0);
        step();
        check_eq("el_vld_c10", b_rpt_vld, 0);
        check_eq("el_cnt_c10", b_err_cnt, 3);
        check_eq("el_fin_c10", b_finish, 0);
        step();
        check_eq("el_fin_c11", b_finish, 1);
        check_eq("el_cnt_end", b_err_cnt, 3);

        // Watchdog of 8 idle cycles.
        do_reset();
        step_to(7);
        check_eq("wd_to_c7", b_timeout, 0);
        step();
        check_eq("wd_to_c8", b_timeout, 1);
        check_eq("wd_fin_c8", b_finish, 0);
        step();
        check_eq("wd_fin_c9", b_finish, 1);
        check_eq("wd_vld_done", b_rpt_vld, 0);

        // Kicks every 7 cycles keep the watchdog quiet.
        do_reset();
        while (cyc < 40) begin
            kick = ((cyc % 7) == 6);
            step();
        end
        kick = 1'b0;
        check_eq("wd_kick_to", b_timeout, 0);
        check_eq("wd_kick_fin", b_finish, 0);

        // Mid-operation reset discards everything.
        do_reset();
        step_to(2);
        for (int i = 0; i < 4; i++) req_msg[i] = 32'hB000_0000 | 32'(i);
        req_vld = 4'b0111;
        step();
        req_vld = '0;
        step();
        check_eq("mr_vld_pre", a_rpt_vld, 1);
        check_eq("mr_rdy_pre", a_req_rdy, 4'b1001);
        arst_n = 1'b0;
        #1;
        check_eq("mr_vld", a_rpt_vld, 0);
        check_eq("mr_id", a_rpt_id, 0);
        check_eq("mr_msg", a_rpt_msg, 0);
        check_eq("mr_stamp", a_rpt_cycle, 0);
        check_eq("mr_tb_cycle", a_tb_cycle, 0);
        check_eq("mr_rdy", a_req_rdy, 4'hF);
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        cyc    = 0;
        step_to(2);
        check_eq("mr_no_stale", a_rpt_vld, 0);
        step_to(3);
        req_vld    = 4'b1000;
        req_msg[3] = 32'hC0DE_0003;
        rpt_rdy    = 1'b1;
        step();
        req_vld = '0;
        step();
        check_eq("mr_new_vld", a_rpt_vld, 1);
        check_eq("mr_new_id", a_rpt_id, 3);
        check_eq("mr_new_msg", a_rpt_msg, 32'hC0DE_0003);
        check_eq("mr_new_stamp", a_rpt_cycle, 3);

        // Sustained error stream: one report per cycle, counter saturates.
        do_reset();
        req_vld = 4'hF;
        req_err = 4'hF;
        rpt_rdy = 1'b1;
        step_to(1002);
        check_eq("sat_tput", c_err_cnt, 1000);
        check_eq("sat_vld", c_rpt_vld, 1);
        step_to(65536);
        check_eq("sat_fffe", c_err_cnt, 16'hFFFE);
        step_to(65537);
        check_eq("sat_ffff", c_err_cnt, 16'hFFFF);
        step_to(65540);
        check_eq("sat_hold", c_err_cnt, 16'hFFFF);
        check_eq("sat_no_fin", c_finish, 0);
        req_vld = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
